// File: rtl/mult_tree_pipe_pkg.sv
// Shared types and partial-product generation for the pipelined tree multiplier.
// Helpers are sized for the widest supported operand and take the active width as an argument.
package mult_pkg;

  localparam int MAX_W = 32;

  typedef enum logic {
    MODE_UNSIGNED = 1'b0,
    MODE_SIGNED   = 1'b1
  } mult_mode_e;

  typedef logic [2*MAX_W-1:0]            ppWord_t;
  typedef logic [MAX_W-1:0][2*MAX_W-1:0] ppArray_t;

  // Row i of the long multiplication; in signed mode the top row of b carries negative weight.
  function automatic ppWord_t pp_term(input logic [MAX_W-1:0] a,
                                      input logic [MAX_W-1:0] b,
                                      input logic             isSigned,
                                      input int               width,
                                      input int               i);
    logic [MAX_W-1:0] aTop;
    logic [MAX_W-1:0] bSel;
    ppWord_t          lowMask;
    ppWord_t          aExt;
    ppWord_t          shifted;
    aTop    = a >> (width - 1);
    bSel    = b >> i;
    lowMask = (ppWord_t'(1) << width) - ppWord_t'(1);
    aExt    = ppWord_t'(a) & lowMask;
    if (isSigned && aTop[0]) aExt = aExt | ~lowMask;
    shifted = aExt << i;
    if (!bSel[0]) pp_term = '0;
    else if (isSigned && (i == width - 1)) pp_term = -shifted;
    else pp_term = shifted;
  endfunction

  function automatic ppArray_t pp_gen(input logic [MAX_W-1:0] a,
                                      input logic [MAX_W-1:0] b,
                                      input logic             isSigned,
                                      input int               width);
    ppArray_t rows;
    rows = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < width) rows[i] = pp_term(a, b, isSigned, width, i);
    end
    return rows;
  endfunction

endpackage

// File: rtl/mult_tree_pipe_tree_level.sv
// One register stage of the adder tree: N_IN words in, N_IN/2 registered pair sums out.
module tree_level #(
  parameter int N_IN = 2,
  parameter int W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     adv_i,
  input  logic                     valid_i,
  input  logic                     signed_i,
  input  logic [N_IN-1:0][W-1:0]   data_i,
  output logic                     valid_o,
  output logic                     signed_o,
  output logic [N_IN/2-1:0][W-1:0] data_o
);

  logic [N_IN/2-1:0][W-1:0] sum_d;
  logic [N_IN/2-1:0][W-1:0] sum_q;
  logic                     valid_q;
  logic                     signed_q;

  // Sums wrap at W bits; the full product always fits so nothing is lost.
  always_comb begin
    sum_d = '0;
    for (int j = 0; j < N_IN/2; j++) begin
      sum_d[j] = data_i[2*j] + data_i[2*j+1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q    <= '0;
      valid_q  <= 1'b0;
      signed_q <= 1'b0;
    end else if (adv_i) begin
      sum_q    <= sum_d;
      valid_q  <= valid_i;
      signed_q <= signed_i;
    end
  end

  assign data_o   = sum_q;
  assign valid_o  = valid_q;
  assign signed_o = signed_q;

endmodule

// File: rtl/mult_tree_pipe.sv
// Fully pipelined WIDTH x WIDTH multiplier: operand register, then one adder-tree stage per level.
// A single global advance signal moves every stage together, so a stalled output freezes the pipe.
module mult_tree_pipe
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               out_signed
);

  localparam int LEVELS = $clog2(WIDTH);

  logic       adv;
  logic       stageValid_d;
  logic       stageValid_q;
  logic [WIDTH-1:0] opA_d;
  logic [WIDTH-1:0] opA_q;
  logic [WIDTH-1:0] opB_d;
  logic [WIDTH-1:0] opB_q;
  mult_mode_e mode_d;
  mult_mode_e mode_q;

  logic [WIDTH-1:0][2*WIDTH-1:0]   pp;
  logic [2*WIDTH-2:0][2*WIDTH-1:0] nodes;
  logic [LEVELS:0]                 vld;
  logic [LEVELS:0]                 sgn;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // A cycle that advances without an accept loads a bubble into stage 0.
  assign stageValid_d = in_valid;
  assign opA_d        = in_a;
  assign opB_d        = in_b;
  assign mode_d       = mult_mode_e'(in_signed);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stageValid_q <= 1'b0;
      opA_q        <= '0;
      opB_q        <= '0;
      mode_q       <= MODE_UNSIGNED;
    end else if (adv) begin
      stageValid_q <= stageValid_d;
      opA_q        <= opA_d;
      opB_q        <= opB_d;
      mode_q       <= mode_d;
    end
  end

  always_comb begin
    pp = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pp[i] = (2*WIDTH)'(pp_term(MAX_W'(opA_q), MAX_W'(opB_q), mode_q == MODE_SIGNED, WIDTH, i));
    end
  end

  // nodes holds every tree level back to back: WIDTH partial products, then WIDTH/2 sums, ...
  assign nodes[WIDTH-1:0] = pp;
  assign vld[0]           = stageValid_q;
  assign sgn[0]           = mode_q;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_level
    localparam int N_IN    = WIDTH >> (k - 1);
    localparam int IN_OFF  = 2*WIDTH - 2*N_IN;
    localparam int OUT_OFF = 2*WIDTH - N_IN;

    tree_level #(
      .N_IN(N_IN),
      .W   (2*WIDTH)
    ) u_level (
      .clk     (clk),
      .rst_n   (rst_n),
      .adv_i   (adv),
      .valid_i (vld[k-1]),
      .signed_i(sgn[k-1]),
      .data_i  (nodes[IN_OFF+N_IN-1:IN_OFF]),
      .valid_o (vld[k]),
      .signed_o(sgn[k]),
      .data_o  (nodes[OUT_OFF+N_IN/2-1:OUT_OFF])
    );
  end

  assign out_p      = nodes[2*WIDTH-2];
  assign out_valid  = vld[LEVELS];
  assign out_signed = sgn[LEVELS];

endmodule

// File: tb/tb_mult_tree_pipe.sv
// Directed bench for mult_tree_pipe at WIDTH=8, plus a WIDTH=16 instance driven by a
// random stream that is checked against native signed/unsigned multiplication.
module tb_mult_tree_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        inValid8, inReady8, inSigned8, outValid8, outReady8, outSigned8;
  logic [7:0]  inA8, inB8;
  logic [15:0] outP8;

  logic        inValid16, inReady16, inSigned16, outValid16, outReady16, outSigned16;
  logic [15:0] inA16, inB16;
  logic [31:0] outP16;

  int checks = 0;
  int errors = 0;

  logic [7:0]  vecA [8] = '{8'd3, 8'd10, 8'd255, 8'd16, 8'hFE, 8'd100, 8'hCE, 8'd7};
  logic [7:0]  vecB [8] = '{8'd5, 8'd20, 8'd2, 8'd16, 8'd3, 8'hFF, 8'hCE, 8'hF9};
  logic        vecS [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [15:0] vecP [8] = '{16'h000F, 16'h00C8, 16'h01FE, 16'h0100,
                            16'hFFFA, 16'hFF9C, 16'h09C4, 16'hFFCF};

  mult_tree_pipe #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inValid8),
    .in_ready  (inReady8),
    .in_a      (inA8),
    .in_b      (inB8),
    .in_signed (inSigned8),
    .out_valid (outValid8),
    .out_ready (outReady8),
    .out_p     (outP8),
    .out_signed(outSigned8)
  );

  mult_tree_pipe #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inValid16),
    .in_ready  (inReady16),
    .in_a      (inA16),
    .in_b      (inB16),
    .in_signed (inSigned16),
    .out_valid (outValid16),
    .out_ready (outReady16),
    .out_p     (outP16),
    .out_signed(outSigned16)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [7:0] b, input logic s);
    inValid8  = v;
    inA8      = a;
    inB8      = b;
    inSigned8 = s;
  endtask

  task automatic drain8();
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b0);
    outReady8 = 1'b1;
    repeat (6) tick();
  endtask

  // One operation into an empty pipe; lat counts edges from the accepting edge to out_valid.
  task automatic sendAndWait(input logic [7:0] a, input logic [7:0] b, input logic s,
                             output int lat, output logic [15:0] p, output logic sg,
                             output logic readyAll);
    lat = 0;
    p = '0;
    sg = 1'b0;
    readyAll = 1'b1;
    outReady8 = 1'b1;
    applyStimulus(1'b1, a, b, s);
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      #1;
      readyAll = readyAll & inReady8;
      tick();
      applyStimulus(1'b0, 8'd0, 8'd0, 1'b0);
      if (outValid8) begin
        lat = c;
        p = outP8;
        sg = outSigned8;
      end
    end
  endtask

  // Streams the eight table vectors; out_ready is held low through cycle stallUntil.
  task automatic runStream8(input string tag, input int stallUntil, input int firstExp);
    int sent, got, extra;
    logic [15:0] gotP [8];
    logic        gotS [8];
    int          gotC [8];
    sent = 0;
    got = 0;
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      gotP[k] = '0;
      gotS[k] = 1'b0;
      gotC[k] = -1;
    end
    for (int c = 0; c < 30; c++) begin
      outReady8 = (c > stallUntil);
      if (sent < 8) applyStimulus(1'b1, vecA[sent], vecB[sent], vecS[sent]);
      else applyStimulus(1'b0, 8'd0, 8'd0, 1'b0);
      #1;
      if (c >= 4 && c <= stallUntil) begin
        checkOutput($sformatf("%s_stall_in_ready_c%0d", tag, c), 32'(inReady8), 32'd0);
        checkOutput($sformatf("%s_stall_valid_c%0d", tag, c), 32'(outValid8), 32'd1);
        checkOutput($sformatf("%s_stall_hold_p_c%0d", tag, c), 32'(outP8), 32'(vecP[0]));
      end
      if (outValid8 && outReady8) begin
        if (got < 8) begin
          gotP[got] = outP8;
          gotS[got] = outSigned8;
          gotC[got] = c;
          got++;
        end else begin
          extra++;
        end
      end
      if (inValid8 && inReady8) sent++;
      tick();
    end
    checkOutput({tag, "_count"}, 32'(got), 32'd8);
    checkOutput({tag, "_extra"}, 32'(extra), 32'd0);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("%s_p%0d", tag, k), 32'(gotP[k]), 32'(vecP[k]));
      checkOutput($sformatf("%s_s%0d", tag, k), 32'(gotS[k]), 32'(vecS[k]));
      checkOutput($sformatf("%s_cycle%0d", tag, k), 32'(gotC[k]), 32'(firstExp + k));
    end
  endtask

  int          lat;
  logic [15:0] p8;
  logic        sg8;
  logic        readyAll;
  int          valids;
  logic [31:0] expQ [$];
  logic        expSQ [$];
  logic [31:0] expP;
  logic        expS;
  logic        pending;
  int          sent16, got16, extra16, sa, sb;

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b0);
    outReady8  = 1'b1;
    inValid16  = 1'b0;
    inA16      = '0;
    inB16      = '0;
    inSigned16 = 1'b0;
    outReady16 = 1'b1;

    $display("[TB] reset");
    repeat (3) tick();
    checkOutput("rst_out_valid", 32'(outValid8), 32'd0);
    checkOutput("rst_out_p", 32'(outP8), 32'd0);
    checkOutput("rst_out_signed", 32'(outSigned8), 32'd0);
    checkOutput("rst_out_valid16", 32'(outValid16), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_in_ready", 32'(inReady8), 32'd1);

    $display("[TB] single unsigned operation");
    sendAndWait(8'd255, 8'd255, 1'b0, lat, p8, sg8, readyAll);
    checkOutput("t1_latency", 32'(lat), 32'd4);
    checkOutput("t1_p", 32'(p8), 32'h0000FE01);
    checkOutput("t1_signed", 32'(sg8), 32'd0);
    checkOutput("t1_in_ready", 32'(readyAll), 32'd1);

    $display("[TB] signed and unsigned corners");
    sendAndWait(8'h80, 8'h80, 1'b1, lat, p8, sg8, readyAll);
    checkOutput("t2_m128xm128", 32'(p8), 32'h00004000);
    checkOutput("t2_m128xm128_s", 32'(sg8), 32'd1);
    sendAndWait(8'hFF, 8'h7F, 1'b1, lat, p8, sg8, readyAll);
    checkOutput("t2_m1x127", 32'(p8), 32'h0000FF81);
    sendAndWait(8'h7F, 8'h80, 1'b1, lat, p8, sg8, readyAll);
    checkOutput("t2_127xm128", 32'(p8), 32'h0000C080);
    sendAndWait(8'h80, 8'h80, 1'b0, lat, p8, sg8, readyAll);
    checkOutput("t2_u128x128", 32'(p8), 32'h00004000);
    checkOutput("t2_u128x128_s", 32'(sg8), 32'd0);

    $display("[TB] back-to-back stream");
    drain8();
    runStream8("t3", -1, 4);

    $display("[TB] stall with full pipe");
    drain8();
    runStream8("t4", 8, 9);

    $display("[TB] reset mid-stream");
    drain8();
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, vecA[c+4], vecB[c+4], vecS[c+4]);
      tick();
    end
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b0);
    outReady8 = 1'b0;
    #1;
    checkOutput("t5_pre_valid", 32'(outValid8), 32'd1);
    checkOutput("t5_pre_p", 32'(outP8), 32'(vecP[4]));
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_valid", 32'(outValid8), 32'd0);
    checkOutput("t5_rst_p", 32'(outP8), 32'd0);
    checkOutput("t5_rst_signed", 32'(outSigned8), 32'd0);
    tick();
    rst_n = 1'b1;
    outReady8 = 1'b1;
    #1;
    checkOutput("t5_in_ready", 32'(inReady8), 32'd1);
    valids = 0;
    repeat (10) begin
      tick();
      if (outValid8) valids++;
    end
    checkOutput("t5_no_ghost", 32'(valids), 32'd0);

    $display("[TB] WIDTH=16 latency");
    outReady16 = 1'b1;
    inA16 = 16'hFFFF;
    inB16 = 16'hFFFF;
    inSigned16 = 1'b0;
    inValid16 = 1'b1;
    lat = 0;
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      tick();
      inValid16 = 1'b0;
      if (outValid16) begin
        lat = c;
        checkOutput("t6_dir_p", outP16, 32'hFFFE0001);
      end
    end
    checkOutput("t6_latency", 32'(lat), 32'd5);
    tick();

    $display("[TB] WIDTH=16 random stream");
    sent16 = 0;
    got16 = 0;
    extra16 = 0;
    pending = 1'b0;
    for (int c = 0; c < 6000 && (got16 < 1000 || c < 10); c++) begin
      outReady16 = ($urandom_range(0, 3) != 0);
      if (!pending && sent16 < 1000) begin
        case ($urandom_range(0, 5))
          0: inA16 = 16'h8000;
          1: inA16 = 16'h7FFF;
          2: inA16 = 16'hFFFF;
          default: inA16 = 16'($urandom);
        endcase
        inB16 = ($urandom_range(0, 5) == 0) ? 16'h8000 : 16'($urandom);
        inSigned16 = 1'($urandom_range(0, 1));
        pending = 1'b1;
      end
      inValid16 = pending;
      #1;
      if (inValid16 && inReady16) begin
        if (inSigned16) begin
          sa = int'($signed(inA16));
          sb = int'($signed(inB16));
          expP = 32'(sa * sb);
        end else begin
          expP = 32'(inA16) * 32'(inB16);
        end
        expQ.push_back(expP);
        expSQ.push_back(inSigned16);
        sent16++;
        pending = 1'b0;
      end
      if (outValid16 && outReady16) begin
        if (expQ.size() > 0) begin
          expP = expQ.pop_front();
          expS = expSQ.pop_front();
          checkOutput($sformatf("t6_rand_p%0d", got16), outP16, expP);
          checkOutput($sformatf("t6_rand_s%0d", got16), 32'(outSigned16), 32'(expS));
          got16++;
        end else begin
          extra16++;
        end
      end
      tick();
    end
    checkOutput("t6_sent", 32'(sent16), 32'd1000);
    checkOutput("t6_received", 32'(got16), 32'd1000);
    checkOutput("t6_extra", 32'(extra16), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
